cpu_flags: RTL

Processor status (P) register unit for the 6502 core. It closes the flag loop around the ALU:
- consumes the ALU carry, zero, sign and overflow outputs;
- stores them as architectural C/Z/N/V flags;
- drives the ALU carry-in from the stored carry.

It also holds the I and D flags and produces the byte pushed by PHP/BRK/IRQ. It applies PLP/RTI loads and SEx/CLx writes. It maintains the instruction-delayed IRQ mask used by the interrupt poller.

---
 rtl/cpu_flags_if.sv | 20 ++
 rtl/cpu_flags.sv | 49 ++++
 2 files changed

// File: rtl/cpu_flags_if.sv
// cpu_flags_if: ALU flag loop, status load/write strobes and P-byte outputs of the 6502 status unit.
interface cpu_flags_if;
  logic       alu_cout, alu_zero, alu_sign, alu_ovf, alu_cin;
  logic [1:0] cin_sel;
  logic       sub_mode, upd_en, bit_load, p_load, flag_wr, flag_val, push_brk, insn_boundary;
  logic [3:0] upd_mask;
  logic [7:0] data_in, p_in, p_out;
  logic [2:0] flag_sel;
  logic       flag_c, flag_d, irq_mask;
  modport master (
    output alu_cout, alu_zero, alu_sign, alu_ovf, cin_sel, sub_mode, upd_en, upd_mask,
           bit_load, data_in, p_load, p_in, flag_wr, flag_sel, flag_val, push_brk, insn_boundary,
    input  alu_cin, p_out, flag_c, flag_d, irq_mask
  );
  modport slave (
    input  alu_cout, alu_zero, alu_sign, alu_ovf, cin_sel, sub_mode, upd_en, upd_mask,
           bit_load, data_in, p_load, p_in, flag_wr, flag_sel, flag_val, push_brk, insn_boundary,
    output alu_cin, p_out, flag_c, flag_d, irq_mask
  );
endinterface

// File: rtl/cpu_flags.sv
// cpu_flags: 6502 P register closing the ALU flag loop, with PLP/SEx/CLx/BIT updates and delayed IRQ mask.
module cpu_flags (
  input logic        clk,
  input logic        reset,
  cpu_flags_if.slave bus
);
  logic c, z, i, d, v, n, irq_q;
  logic c_n, z_n, i_n, d_n, v_n, n_n;
  logic cv;
  // Only the highest-priority strobe takes effect; no per-bit merging between strobes.
  always_comb begin
    {n_n, v_n, d_n, i_n, z_n, c_n} = {n, v, d, i, z, c};
    if (bus.p_load) begin
      {n_n, v_n, d_n, i_n, z_n, c_n} = {bus.p_in[7:6], bus.p_in[3:0]};
    end else if (bus.flag_wr) begin
      c_n = bus.flag_sel == 3'd0 ? bus.flag_val : c;
      z_n = bus.flag_sel == 3'd1 ? bus.flag_val : z;
      i_n = bus.flag_sel == 3'd2 ? bus.flag_val : i;
      d_n = bus.flag_sel == 3'd3 ? bus.flag_val : d;
      v_n = bus.flag_sel == 3'd6 ? bus.flag_val : v;
      n_n = bus.flag_sel == 3'd7 ? bus.flag_val : n;
    end else if (bus.bit_load) begin
      n_n = bus.data_in[7];
      v_n = bus.data_in[6];
      z_n = bus.alu_zero;
    end else if (bus.upd_en) begin
      n_n = bus.upd_mask[3] ? bus.alu_sign : n;
      v_n = bus.upd_mask[2] ? bus.alu_ovf : v;
      z_n = bus.upd_mask[1] ? bus.alu_zero : z;
      c_n = bus.upd_mask[0] ? bus.alu_cout ^ bus.sub_mode : c;
    end
  end
  assign cv = bus.cin_sel == 2'b10 ? 1'b1 : (bus.cin_sel == 2'b00 ? c : 1'b0);
  assign bus.alu_cin  = cv ^ bus.sub_mode;
  assign bus.p_out    = {n, v, 1'b1, bus.push_brk, d, i, z, c};
  assign bus.flag_c   = c;
  assign bus.flag_d   = d;
  assign bus.irq_mask = irq_q;
  // irq_q samples the pre-update I, giving the one-instruction CLI/SEI/PLP latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {n, v, d, i, z, c} <= 6'b000100;
      irq_q <= 1'b1;
    end else begin
      {n, v, d, i, z, c} <= {n_n, v_n, d_n, i_n, z_n, c_n};
      if (bus.insn_boundary) irq_q <= i;
    end
  end
endmodule
